// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// opcode/funct constants, ALU op codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR,
        WB_R, WB_I, WB_MEM, BRANCH, JUMP, TRAP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_ADDU = 4'b1111;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SUBU = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b0101;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    function automatic logic opcode_known(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LUI) ||
               (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
    endfunction

    // States that issue a memory request; entering one restarts the wait count.
    function automatic logic is_mem_state(input state_e s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational R-type funct -> ALU op decoder; unknown funct decodes as ADD
// and is flagged through funct_ok_o.
module mc_alu_dec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic [5:0]         funct_i,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               funct_ok_o
);

    always_comb begin
        alu_op_o   = ALUOP_W'(ALU_ADD);
        funct_ok_o = 1'b1;
        case (funct_i)
            FN_ADD:  alu_op_o = ALUOP_W'(ALU_ADD);
            FN_ADDU: alu_op_o = ALUOP_W'(ALU_ADDU);
            FN_SUB:  alu_op_o = ALUOP_W'(ALU_SUB);
            FN_SUBU: alu_op_o = ALUOP_W'(ALU_SUBU);
            FN_NOR:  alu_op_o = ALUOP_W'(ALU_NOR);
            FN_XOR:  alu_op_o = ALUOP_W'(ALU_XOR);
            FN_SLT:  alu_op_o = ALUOP_W'(ALU_SLT);
            FN_SLTU: alu_op_o = ALUOP_W'(ALU_SLTU);
            default: funct_ok_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready stalls and a sticky wait timeout.
// Optional MC_CTRL_TRAP_EN: unknown opcode/funct parks the FSM in TRAP until reset.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 -> PC on mem_rdy
// DECODE | branch target -> ALUOut, dispatch on opcode
// EXEC_R | R-type ALU operation
// EXEC_I | ADDI / LUI ALU operation
// ADDR   | load/store effective address
// MEM_RD | data read, wait for mem_rdy
// MEM_WR | data write, retire on mem_rdy
// WB_R   | write rd from ALUOut
// WB_I   | write rt from ALUOut
// WB_MEM | write rt from MDR
// BRANCH | BEQ compare, conditional PC update
// JUMP   | PC <- jump target
// TRAP   | illegal instruction, hold until reset
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W      = 4,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         opcode_i,
    input  logic [5:0]         funct_i,
    input  logic               zero_i,
    input  logic               mem_rdy_i,
    output logic               pc_we_o,
    output logic [1:0]         pc_src_o,
    output logic               ir_we_o,
    output logic               iord_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               reg_dst_o,
    output logic               reg_we_o,
    output logic               mem2reg_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic               ext_op_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               instr_done_o,
    output logic               mem_timeout_o
`ifdef MC_CTRL_TRAP_EN
    ,
    output logic               trap_o
`endif
);

    localparam int WAIT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                timeout_q, timeout_d;
    logic [ALUOP_W-1:0]  funct_alu_op;
    logic                funct_ok;

    mc_alu_dec #(.ALUOP_W(ALUOP_W)) u_alu_dec (
        .funct_i    (funct_i),
        .alu_op_o   (funct_alu_op),
        .funct_ok_o (funct_ok)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (mem_rdy_i) state_d = DECODE;
            DECODE: begin
                case (opcode_i)
`ifdef MC_CTRL_TRAP_EN
                    OP_RTYPE: state_d = funct_ok ? EXEC_R : TRAP;
                    default:  state_d = TRAP;
`else
                    OP_RTYPE: state_d = EXEC_R;
                    default:  state_d = FETCH;
`endif
                    OP_ADDI, OP_LUI: state_d = EXEC_I;
                    OP_LW, OP_SW:    state_d = ADDR;
                    OP_BEQ:          state_d = BRANCH;
                    OP_J:            state_d = JUMP;
                endcase
            end
            EXEC_R: state_d = WB_R;
            EXEC_I: state_d = WB_I;
            ADDR:   state_d = (opcode_i == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD: if (mem_rdy_i) state_d = WB_MEM;
            MEM_WR: if (mem_rdy_i) state_d = FETCH;
            TRAP:   state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        wait_d = wait_q;
        if (is_mem_state(state_d) && (state_d != state_q)) begin
            wait_d = '0;
        end else if (mem_req_o && !mem_rdy_i && (wait_q != WAIT_SAT)) begin
            wait_d = wait_q + 1'b1;
        end
        timeout_d = timeout_q || ((MEM_WAIT_MAX != 0) && (wait_d == WAIT_LIM));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        pc_we_o      = 1'b0;
        pc_src_o     = PC_SRC_SEQ;
        ir_we_o      = 1'b0;
        iord_o       = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        reg_dst_o    = 1'b0;
        reg_we_o     = 1'b0;
        mem2reg_o    = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_RT;
        ext_op_o     = 1'b1;
        alu_op_o     = ALUOP_W'(ALU_ADD);
        instr_done_o = 1'b0;
`ifdef MC_CTRL_TRAP_EN
        trap_o       = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                ir_we_o     = mem_rdy_i;
                pc_we_o     = mem_rdy_i;
            end
            DECODE: begin
                alu_src_b_o = SRCB_IMM_SH;
`ifdef MC_CTRL_TRAP_EN
                instr_done_o = 1'b0;
`else
                instr_done_o = !opcode_known(opcode_i);
`endif
            end
            EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = funct_alu_op;
            end
            EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                if (opcode_i == OP_LUI) begin
                    ext_op_o = 1'b0;
                    alu_op_o = ALUOP_W'(ALU_LUI);
                end
            end
            ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            MEM_RD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
            end
            MEM_WR: begin
                mem_req_o    = 1'b1;
                iord_o       = 1'b1;
                mem_we_o     = 1'b1;
                instr_done_o = mem_rdy_i;
            end
            WB_R: begin
                reg_we_o     = 1'b1;
                reg_dst_o    = 1'b1;
                instr_done_o = 1'b1;
            end
            WB_I: begin
                reg_we_o     = 1'b1;
                instr_done_o = 1'b1;
            end
            WB_MEM: begin
                reg_we_o     = 1'b1;
                mem2reg_o    = 1'b1;
                instr_done_o = 1'b1;
            end
            BRANCH: begin
                alu_src_a_o  = 1'b1;
                alu_op_o     = ALUOP_W'(ALU_SUB);
                pc_we_o      = zero_i;
                pc_src_o     = PC_SRC_BR;
                instr_done_o = 1'b1;
            end
            JUMP: begin
                pc_we_o      = 1'b1;
                pc_src_o     = PC_SRC_JMP;
                instr_done_o = 1'b1;
            end
`ifdef MC_CTRL_TRAP_EN
            TRAP: trap_o = 1'b1;
`endif
            default: ;
        endcase
    end

    assign mem_timeout_o = timeout_q;

`ifdef MC_CTRL_TRAP_EN
`else
    // Unknown funct simply executes as ADD when trapping is disabled.
    logic unused_funct_ok;
    assign unused_funct_ok = funct_ok;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed-vector bench for mc_ctrl (MEM_WAIT_MAX=4); expectations hand-computed.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] opcode_i, funct_i;
    logic       zero_i, mem_rdy_i;
    logic       pc_we_o, ir_we_o, iord_o, mem_req_o, mem_we_o, reg_dst_o, reg_we_o;
    logic       mem2reg_o, alu_src_a_o, ext_op_o, instr_done_o, mem_timeout_o;
    logic [1:0] pc_src_o, alu_src_b_o;
    logic [3:0] alu_op_o;
`ifdef MC_CTRL_TRAP_EN
    logic       trap_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    mc_ctrl #(.ALUOP_W(4), .MEM_WAIT_MAX(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i),
        .zero_i(zero_i), .mem_rdy_i(mem_rdy_i), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o),
        .ir_we_o(ir_we_o), .iord_o(iord_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .reg_dst_o(reg_dst_o), .reg_we_o(reg_we_o), .mem2reg_o(mem2reg_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .ext_op_o(ext_op_o),
        .alu_op_o(alu_op_o), .instr_done_o(instr_done_o), .mem_timeout_o(mem_timeout_o)
`ifdef MC_CTRL_TRAP_EN
        , .trap_o(trap_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy);
        opcode_i  = op;
        funct_i   = fn;
        zero_i    = z;
        mem_rdy_i = rdy;
        #1;
    endtask

    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_r(input string nm, input logic [5:0] fn, input logic [3:0] exp_alu);
        drv(OP_RTYPE, fn, 1'b0, 1'b1);
        chk({nm, "_c1_ir_we"}, ir_we_o, 1);
        chk({nm, "_c1_pc_we"}, pc_we_o, 1);
        chk({nm, "_c1_pc_src"}, pc_src_o, 0);
        next_cyc();
        drv(OP_RTYPE, fn, 1'b0, 1'b1);
        chk({nm, "_c2_srcb"}, alu_src_b_o, 3);
        chk({nm, "_c2_req"}, mem_req_o, 0);
        next_cyc();
        drv(OP_RTYPE, fn, 1'b0, 1'b1);
        chk({nm, "_c3_alu_op"}, alu_op_o, exp_alu);
        chk({nm, "_c3_srca"}, alu_src_a_o, 1);
        chk({nm, "_c3_srcb"}, alu_src_b_o, 0);
        chk({nm, "_c3_reg_we"}, reg_we_o, 0);
        next_cyc();
        drv(OP_RTYPE, fn, 1'b0, 1'b1);
        chk({nm, "_c4_reg_we"}, reg_we_o, 1);
        chk({nm, "_c4_reg_dst"}, reg_dst_o, 1);
        chk({nm, "_c4_done"}, instr_done_o, 1);
        chk({nm, "_c4_mem2reg"}, mem2reg_o, 0);
        next_cyc();
    endtask

    // Fetch (zero wait) and decode; leaves the bench at the start of cycle 3.
    task automatic fetch_decode(input logic [5:0] op, input logic z);
        drv(op, 6'd0, z, 1'b1);
        next_cyc();
        drv(op, 6'd0, z, 1'b1);
        next_cyc();
    endtask

    logic [5:0] fn_tab [8] = '{FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_NOR, FN_XOR, FN_SLT, FN_SLTU};
    logic [3:0] alu_tab[8] = '{4'b0000, 4'b1111, 4'b0010, 4'b0011, 4'b1000, 4'b1001, 4'b0110, 4'b0111};

    initial begin
        rst_i = 1'b1;
        drv(6'd0, 6'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        drv(OP_RTYPE, FN_ADD, 1'b0, 1'b0);
        chk("rst_mem_req", mem_req_o, 1);
        chk("rst_iord", iord_o, 0);
        chk("rst_srcb", alu_src_b_o, 1);
        chk("rst_ir_we", ir_we_o, 0);
        chk("rst_pc_we", pc_we_o, 0);
        chk("rst_done", instr_done_o, 0);
        chk("rst_timeout", mem_timeout_o, 0);
        chk("rst_ext_op", ext_op_o, 1);
        next_cyc();

        for (int i = 0; i < 8; i++) run_r($sformatf("r%0d", i), fn_tab[i], alu_tab[i]);
`ifndef MC_CTRL_TRAP_EN
        run_r("r_badfn", 6'b000101, 4'b0000);
`endif

        // LW with three wait cycles in MEM_RD: 8 cycles total
        fetch_decode(OP_LW, 1'b0);
        drv(OP_LW, 6'd0, 1'b0, 1'b0);
        chk("lw_addr_srcb", alu_src_b_o, 2);
        chk("lw_addr_ext", ext_op_o, 1);
        chk("lw_addr_alu", alu_op_o, 0);
        next_cyc();
        for (int i = 0; i < 4; i++) begin
            drv(OP_LW, 6'd0, 1'b0, (i == 3));
            chk($sformatf("lw_rd%0d_req", i), mem_req_o, 1);
            chk($sformatf("lw_rd%0d_iord", i), iord_o, 1);
            chk($sformatf("lw_rd%0d_we", i), mem_we_o, 0);
            chk($sformatf("lw_rd%0d_done", i), instr_done_o, 0);
            next_cyc();
        end
        drv(OP_LW, 6'd0, 1'b0, 1'b1);
        chk("lw_wb_reg_we", reg_we_o, 1);
        chk("lw_wb_mem2reg", mem2reg_o, 1);
        chk("lw_wb_reg_dst", reg_dst_o, 0);
        chk("lw_wb_done", instr_done_o, 1);
        chk("lw_timeout", mem_timeout_o, 0);
        next_cyc();

        // SW zero wait: retires in cycle 4
        fetch_decode(OP_SW, 1'b0);
        next_cyc();
        drv(OP_SW, 6'd0, 1'b0, 1'b1);
        chk("sw_we", mem_we_o, 1);
        chk("sw_req", mem_req_o, 1);
        chk("sw_iord", iord_o, 1);
        chk("sw_done", instr_done_o, 1);
        chk("sw_reg_we", reg_we_o, 0);
        next_cyc();

        // BEQ taken then not taken
        fetch_decode(OP_BEQ, 1'b1);
        drv(OP_BEQ, 6'd0, 1'b1, 1'b1);
        chk("beq1_pc_we", pc_we_o, 1);
        chk("beq1_pc_src", pc_src_o, 1);
        chk("beq1_alu", alu_op_o, 4'b0010);
        chk("beq1_done", instr_done_o, 1);
        next_cyc();
        fetch_decode(OP_BEQ, 1'b0);
        drv(OP_BEQ, 6'd0, 1'b0, 1'b1);
        chk("beq0_pc_we", pc_we_o, 0);
        chk("beq0_done", instr_done_o, 1);
        next_cyc();

        fetch_decode(OP_J, 1'b0);
        drv(OP_J, 6'd0, 1'b0, 1'b1);
        chk("j_pc_we", pc_we_o, 1);
        chk("j_pc_src", pc_src_o, 2);
        chk("j_done", instr_done_o, 1);
        next_cyc();

        fetch_decode(OP_ADDI, 1'b0);
        drv(OP_ADDI, 6'd0, 1'b0, 1'b1);
        chk("addi_ext", ext_op_o, 1);
        chk("addi_alu", alu_op_o, 0);
        chk("addi_srcb", alu_src_b_o, 2);
        next_cyc();
        drv(OP_ADDI, 6'd0, 1'b0, 1'b1);
        chk("addi_wb_we", reg_we_o, 1);
        chk("addi_wb_dst", reg_dst_o, 0);
        chk("addi_wb_done", instr_done_o, 1);
        next_cyc();

        fetch_decode(OP_LUI, 1'b0);
        drv(OP_LUI, 6'd0, 1'b0, 1'b1);
        chk("lui_ext", ext_op_o, 0);
        chk("lui_alu", alu_op_o, 4'b0101);
        next_cyc();
        next_cyc();

        // Reset while LW waits in MEM_RD
        fetch_decode(OP_LW, 1'b0);
        next_cyc();
        drv(OP_LW, 6'd0, 1'b0, 1'b0);
        chk("mid_rd_iord", iord_o, 1);
        rst_i = 1'b1;
        next_cyc();
        next_cyc();
        rst_i = 1'b0;
        drv(OP_LW, 6'd0, 1'b0, 1'b0);
        chk("mid_rst_req", mem_req_o, 1);
        chk("mid_rst_iord", iord_o, 0);
        chk("mid_rst_reg_we", reg_we_o, 0);
        chk("mid_rst_mem_we", mem_we_o, 0);
        chk("mid_rst_timeout", mem_timeout_o, 0);
        next_cyc();

        // Unknown opcode
        fetch_decode(6'b111111, 1'b0);
`ifdef MC_CTRL_TRAP_EN
        drv(6'b111111, 6'd0, 1'b0, 1'b1);
        chk("bad_op_trap", trap_o, 1);
        chk("bad_op_req", mem_req_o, 0);
        repeat (3) next_cyc();
        chk("bad_op_trap_hold", trap_o, 1);
        chk("bad_op_pc_we", pc_we_o, 0);
        rst_i = 1'b1;
        next_cyc();
        rst_i = 1'b0;
        drv(OP_RTYPE, 6'b000101, 1'b0, 1'b1);
        chk("trap_clr", trap_o, 0);
        next_cyc();
        next_cyc();
        drv(OP_RTYPE, 6'b000101, 1'b0, 1'b1);
        chk("bad_fn_trap", trap_o, 1);
        chk("bad_fn_reg_we", reg_we_o, 0);
`else
        drv(6'b111111, 6'd0, 1'b0, 1'b1);
        chk("bad_op_c3_req", mem_req_o, 1);
        chk("bad_op_c3_iord", iord_o, 0);
        chk("bad_op_c3_done", instr_done_o, 0);
`endif

        // Timeout: FETCH stalls, flag rises after 4 wait cycles and sticks
        rst_i = 1'b1;
        next_cyc();
        rst_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drv(OP_J, 6'd0, 1'b0, 1'b0);
            chk($sformatf("to_wait%0d", i), mem_timeout_o, 0);
            next_cyc();
        end
        drv(OP_J, 6'd0, 1'b0, 1'b0);
        chk("to_set", mem_timeout_o, 1);
        repeat (6) next_cyc();
        drv(OP_J, 6'd0, 1'b0, 1'b1);
        chk("to_ir_we", ir_we_o, 1);
        next_cyc();
        next_cyc();
        drv(OP_J, 6'd0, 1'b0, 1'b1);
        chk("to_j_pc_src", pc_src_o, 2);
        chk("to_sticky", mem_timeout_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
